edc_wb_ctrl: RTL and testbench

Registered, parametrised SECDED error-detect-and-correct controller sitting between a Wishbone slave port and a word-wide main memory holding data and check bits side by side. It splits each bus word into independent 32-bit lanes, each with its own (39,32) Hamming SECDED code. It corrects single-bit errors on read, optionally writing the corrected word back. Byte-masked writes are done as read-modify-write, and corrected/uncorrectable events are counted for software.

---
 rtl/edc_wb_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_edc_wb_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edc_wb_ctrl.sv
// SECDED (39,32) error-detect-and-correct controller between a Wishbone slave and word-wide memory.
// Optional macro EDC_WRITEBACK_EN: reads with a corrected error write the repaired word back.
module edc_wb_ctrl #(
    parameter int WB_DWIDTH = 128,
    parameter int WB_SWIDTH = 16,
    parameter int ADR_W     = 28,
    parameter int CNT_W     = 16
) (
    input  logic                        edc_clk,
    input  logic                        edc_rst_n,
    input  logic [31:0]                 edc_wb_adr,
    input  logic [WB_SWIDTH-1:0]        edc_wb_sel,
    input  logic                        edc_wb_we,
    input  logic [WB_DWIDTH-1:0]        edc_wb_dat_w,
    output logic [WB_DWIDTH-1:0]        edc_wb_dat_r,
    input  logic                        edc_wb_cyc,
    input  logic                        edc_wb_stb,
    output logic                        edc_wb_ack,
    output logic                        edc_wb_err,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [ADR_W-1:0]            mem_adr,
    output logic [39*(WB_DWIDTH/32)-1:0] mem_wdat,
    input  logic [39*(WB_DWIDTH/32)-1:0] mem_rdat,
    input  logic                        edc_cnt_clr,
    output logic [CNT_W-1:0]            edc_ce_cnt,
    output logic [CNT_W-1:0]            edc_ue_cnt,
    output logic [ADR_W-1:0]            edc_err_adr
);

    localparam int LANES = WB_DWIDTH / 32;
    localparam int MW    = 39 * LANES;
    localparam int SH    = $clog2(WB_SWIDTH);

`ifdef EDC_WRITEBACK_EN
    localparam logic WB_EN = 1'b1;
`else
    localparam logic WB_EN = 1'b0;
`endif

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WR   = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_CHK  = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;

    // Data bit k lives at the k-th non-power-of-two codeword position (3,5,6,7,9,...,38);
    // XOR-ing the positions of all set data bits yields the six Hamming bits directly.
    function automatic logic [6:0] encLane(input logic [31:0] d);
        logic [6:0] c;
        logic [5:0] k;
        c = '0;
        k = '0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[k[4:0]]) begin
                    c[5:0] = c[5:0] ^ 6'(p);
                end
                k = k + 6'd1;
            end
        end
        c[6] = ^{d, c[5:0]};
        return c;
    endfunction

    // Returns {uncorrectable, corrected, data}; a hit on a check position leaves data untouched.
    function automatic logic [33:0] decLane(input logic [38:0] w);
        logic [31:0] d;
        logic [6:0]  recomputed;
        logic [5:0]  syn;
        logic        par;
        logic [5:0]  k;
        d          = w[31:0];
        recomputed = encLane(w[31:0]);
        syn        = w[37:32] ^ recomputed[5:0];
        par        = ^w;
        k          = '0;
        for (int p = 3; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (par && (syn == 6'(p))) begin
                    d[k[4:0]] = ~d[k[4:0]];
                end
                k = k + 6'd1;
            end
        end
        return {(!par && (syn != 6'd0)), par, d};
    endfunction

    function automatic logic [MW-1:0] encWord(input logic [WB_DWIDTH-1:0] d);
        logic [MW-1:0] e;
        e = '0;
        for (int l = 0; l < LANES; l++) begin
            e[39*l +: 39] = {encLane(d[32*l +: 32]), d[32*l +: 32]};
        end
        return e;
    endfunction

    logic [2:0]           state_q, state_d;
    logic [ADR_W-1:0]     adr_q, adr_d;
    logic [WB_SWIDTH-1:0] sel_q, sel_d;
    logic                 we_q, we_d;
    logic                 full_q, full_d;
    logic [WB_DWIDTH-1:0] wbDat_q, wbDat_d;
    logic [MW-1:0]        memWdat_q, memWdat_d;
    logic [WB_DWIDTH-1:0] datR_q, datR_d;
    logic                 ce_q, ce_d;
    logic                 ue_q, ue_d;
    logic [CNT_W-1:0]     ceCnt_q, ceCnt_d;
    logic [CNT_W-1:0]     ueCnt_q, ueCnt_d;
    logic [ADR_W-1:0]     errAdr_q, errAdr_d;

    logic [WB_DWIDTH-1:0] decData;
    logic                 anyCe;
    logic                 anyUe;
    logic [33:0]          laneRes;
    logic [WB_DWIDTH-1:0] mergedData;
    logic [WB_SWIDTH-1:0] mergeMask;
    logic                 reqFull;
    logic                 partialRmw;
    logic                 finWrite;

    always_comb begin
        decData = '0;
        anyCe   = 1'b0;
        anyUe   = 1'b0;
        laneRes = '0;
        for (int l = 0; l < LANES; l++) begin
            laneRes               = decLane(mem_rdat[39*l +: 39]);
            decData[32*l +: 32]   = laneRes[31:0];
            anyCe                 = anyCe | laneRes[32];
            anyUe                 = anyUe | laneRes[33];
        end
    end

    // Reads use an empty mask so the corrected word is re-encoded unchanged for writeback.
    assign mergeMask = we_q ? sel_q : '0;

    always_comb begin
        mergedData = decData;
        for (int b = 0; b < WB_SWIDTH; b++) begin
            if (mergeMask[b]) begin
                mergedData[8*b +: 8] = wbDat_q[8*b +: 8];
            end
        end
    end

    assign reqFull    = edc_wb_we && (edc_wb_sel == '1);
    assign partialRmw = we_q && !full_q;
    assign finWrite   = (state_q == ST_FIN) && (partialRmw ? !ue_q : (WB_EN && ce_q));

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        we_d      = we_q;
        full_d    = full_q;
        wbDat_d   = wbDat_q;
        memWdat_d = memWdat_q;
        datR_d    = datR_q;
        ce_d      = ce_q;
        ue_d      = ue_q;
        case (state_q)
            ST_IDLE: begin
                if (edc_wb_cyc && edc_wb_stb) begin
                    adr_d     = ADR_W'(edc_wb_adr >> SH);
                    sel_d     = edc_wb_sel;
                    we_d      = edc_wb_we;
                    full_d    = reqFull;
                    wbDat_d   = edc_wb_dat_w;
                    memWdat_d = encWord(edc_wb_dat_w);
                    state_d   = reqFull ? ST_WR : ST_RD;
                end
            end
            ST_WR:  state_d = ST_IDLE;
            ST_RD:  state_d = ST_CHK;
            ST_CHK: begin
                datR_d    = decData;
                ce_d      = anyCe && !anyUe;
                ue_d      = anyUe;
                memWdat_d = encWord(mergedData);
                state_d   = ST_FIN;
            end
            ST_FIN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One count per access; a clear in the same cycle wins and the event is dropped.
    always_comb begin
        ceCnt_d  = ceCnt_q;
        ueCnt_d  = ueCnt_q;
        errAdr_d = errAdr_q;
        if (edc_cnt_clr) begin
            ceCnt_d  = '0;
            ueCnt_d  = '0;
            errAdr_d = '0;
        end else if (state_q == ST_FIN) begin
            if (ce_q && (ceCnt_q != '1)) begin
                ceCnt_d = ceCnt_q + CNT_W'(1);
            end
            if (ue_q && (ueCnt_q != '1)) begin
                ueCnt_d = ueCnt_q + CNT_W'(1);
            end
            if (ce_q || ue_q) begin
                errAdr_d = adr_q;
            end
        end
    end

    always_ff @(posedge edc_clk) begin
        if (!edc_rst_n) begin
            state_q   <= ST_IDLE;
            adr_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            full_q    <= 1'b0;
            wbDat_q   <= '0;
            memWdat_q <= '0;
            datR_q    <= '0;
            ce_q      <= 1'b0;
            ue_q      <= 1'b0;
            ceCnt_q   <= '0;
            ueCnt_q   <= '0;
            errAdr_q  <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            full_q    <= full_d;
            wbDat_q   <= wbDat_d;
            memWdat_q <= memWdat_d;
            datR_q    <= datR_d;
            ce_q      <= ce_d;
            ue_q      <= ue_d;
            ceCnt_q   <= ceCnt_d;
            ueCnt_q   <= ueCnt_d;
            errAdr_q  <= errAdr_d;
        end
    end

    assign edc_wb_ack   = (state_q == ST_WR) || (state_q == ST_FIN);
    assign edc_wb_err   = (state_q == ST_FIN) && ue_q;
    assign edc_wb_dat_r = datR_q;
    assign mem_req      = (state_q == ST_WR) || (state_q == ST_RD) || finWrite;
    assign mem_we       = (state_q == ST_WR) || finWrite;
    assign mem_adr      = adr_q;
    assign mem_wdat     = memWdat_q;
    assign edc_ce_cnt   = ceCnt_q;
    assign edc_ue_cnt   = ueCnt_q;
    assign edc_err_adr  = errAdr_q;

endmodule

// File: tb/tb_edc_wb_ctrl.sv
// Directed self-checking bench for edc_wb_ctrl with a 16-word memory model and read-path bit-flip injection.
module tb_edc_wb_ctrl;

    localparam logic [127:0] D1    = 128'h0123456789ABCDEF_0123456789ABCDEF;
    localparam logic [127:0] ONES1 = 128'h11111111111111111111111111111111;
    localparam logic [127:0] AAAA  = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;

`ifdef EDC_WRITEBACK_EN
    localparam int EXP_WB = 1;
`else
    localparam int EXP_WB = 0;
`endif

    logic         edc_clk;
    logic         edc_rst_n;
    logic [31:0]  edc_wb_adr;
    logic [15:0]  edc_wb_sel;
    logic         edc_wb_we;
    logic [127:0] edc_wb_dat_w;
    logic [127:0] edc_wb_dat_r;
    logic         edc_wb_cyc;
    logic         edc_wb_stb;
    logic         edc_wb_ack;
    logic         edc_wb_err;
    logic         mem_req;
    logic         mem_we;
    logic [27:0]  mem_adr;
    logic [155:0] mem_wdat;
    logic [155:0] mem_rdat;
    logic         edc_cnt_clr;
    logic [3:0]   edc_ce_cnt;
    logic [3:0]   edc_ue_cnt;
    logic [27:0]  edc_err_adr;

    logic [155:0] mem [0:15];
    logic [155:0] flipMask;
    int           memWrites;
    int           checks;
    int           fails;

    edc_wb_ctrl #(.WB_DWIDTH(128), .WB_SWIDTH(16), .ADR_W(28), .CNT_W(4)) dut (
        .edc_clk(edc_clk), .edc_rst_n(edc_rst_n),
        .edc_wb_adr(edc_wb_adr), .edc_wb_sel(edc_wb_sel), .edc_wb_we(edc_wb_we),
        .edc_wb_dat_w(edc_wb_dat_w), .edc_wb_dat_r(edc_wb_dat_r),
        .edc_wb_cyc(edc_wb_cyc), .edc_wb_stb(edc_wb_stb),
        .edc_wb_ack(edc_wb_ack), .edc_wb_err(edc_wb_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
        .mem_wdat(mem_wdat), .mem_rdat(mem_rdat),
        .edc_cnt_clr(edc_cnt_clr), .edc_ce_cnt(edc_ce_cnt),
        .edc_ue_cnt(edc_ue_cnt), .edc_err_adr(edc_err_adr)
    );

    initial edc_clk = 1'b0;
    always #5 edc_clk = ~edc_clk;

    // Memory model: one-cycle read latency, read data optionally corrupted by flipMask.
    always @(posedge edc_clk) begin
        if (!edc_rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (mem_req && mem_we) begin
            mem[mem_adr[3:0]] <= mem_wdat;
            memWrites         <= memWrites + 1;
        end else if (mem_req) begin
            mem_rdat <= mem[mem_adr[3:0]] ^ flipMask;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] dataOf(input logic [155:0] w);
        return {w[155:124], w[116:85], w[77:46], w[38:7] >> 0 == 0 ? w[31:0] : w[31:0]};
    endfunction

    // Independent syndrome check: place each stored bit at its codeword position and XOR positions.
    function automatic logic laneClean(input logic [38:0] w);
        logic [38:0] byPos;
        logic [5:0]  syn;
        int          di;
        byPos = '0;
        di    = 0;
        for (int pos = 1; pos < 39; pos++) begin
            case (pos)
                1:  byPos[pos] = w[32];
                2:  byPos[pos] = w[33];
                4:  byPos[pos] = w[34];
                8:  byPos[pos] = w[35];
                16: byPos[pos] = w[36];
                32: byPos[pos] = w[37];
                default: begin
                    byPos[pos] = w[di];
                    di++;
                end
            endcase
        end
        syn = '0;
        for (int pos = 1; pos < 39; pos++) if (byPos[pos]) syn = syn ^ 6'(pos);
        return (syn == 6'd0) && ((^w) == 1'b0);
    endfunction

    task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [15:0] sel,
                                 input logic [127:0] dat, input bit clrAtAck,
                                 output logic [127:0] rdat, output logic rerr, output int lat,
                                 output logic ackWr);
        bit got;
        edc_wb_we    = we;
        edc_wb_adr   = adr;
        edc_wb_sel   = sel;
        edc_wb_dat_w = dat;
        edc_wb_cyc   = 1'b1;
        edc_wb_stb   = 1'b1;
        rdat  = '0;
        rerr  = 1'b0;
        lat   = -1;
        ackWr = 1'b0;
        got   = 1'b0;
        @(posedge edc_clk);
        for (int k = 1; k <= 8; k++) begin
            if (!got) begin
                #1;
                if (edc_wb_ack) begin
                    got        = 1'b1;
                    lat        = k;
                    rdat       = edc_wb_dat_r;
                    rerr       = edc_wb_err;
                    ackWr      = mem_req && mem_we;
                    edc_wb_cyc = 1'b0;
                    edc_wb_stb = 1'b0;
                    if (clrAtAck) edc_cnt_clr = 1'b1;
                end else begin
                    @(posedge edc_clk);
                end
            end
        end
        if (!got) begin
            checkOutput("ackTimeout", 0, 1);
            edc_wb_cyc = 1'b0;
            edc_wb_stb = 1'b0;
        end
        @(posedge edc_clk);
        #1;
        edc_cnt_clr = 1'b0;
    endtask

    logic [127:0] rd;
    logic         er;
    logic         aw;
    int           lat;
    int           w0;
    bit           sawAck;
    bit           sawReq;

    initial begin
        checks = 0; fails = 0; memWrites = 0; flipMask = '0;
        edc_rst_n = 1'b0; edc_wb_adr = '0; edc_wb_sel = '0; edc_wb_we = 1'b0;
        edc_wb_dat_w = '0; edc_wb_cyc = 1'b0; edc_wb_stb = 1'b0; edc_cnt_clr = 1'b0;
        repeat (3) @(posedge edc_clk);
        #1;
        checkOutput("rstAck", edc_wb_ack, 0);
        checkOutput("rstErr", edc_wb_err, 0);
        checkOutput("rstDatR", edc_wb_dat_r, 0);
        checkOutput("rstMemReq", mem_req, 0);
        checkOutput("rstMemWe", mem_we, 0);
        checkOutput("rstMemAdr", mem_adr, 0);
        checkOutput("rstMemWdat", mem_wdat, 0);
        checkOutput("rstCeCnt", edc_ce_cnt, 0);
        checkOutput("rstUeCnt", edc_ue_cnt, 0);
        checkOutput("rstErrAdr", edc_err_adr, 0);
        edc_rst_n = 1'b1;
        @(posedge edc_clk);
        #1;

        // Full write then clean read of word 5
        w0 = memWrites;
        applyStimulus(1'b1, 32'h50, 16'hFFFF, D1, 1'b0, rd, er, lat, aw);
        checkOutput("fullWrLat", lat, 1);
        checkOutput("fullWrAckWrite", aw, 1);
        checkOutput("fullWrErr", er, 0);
        checkOutput("fullWrCount", memWrites - w0, 1);
        checkOutput("fullWrData", {mem[5][148:117], mem[5][109:78], mem[5][70:39], mem[5][31:0]}, D1);
        for (int l = 0; l < 4; l++) checkOutput("fullWrClean", laneClean(mem[5][39*l +: 39]), 1);
        applyStimulus(1'b0, 32'h50, 16'hFFFF, '0, 1'b0, rd, er, lat, aw);
        checkOutput("rdLat", lat, 3);
        checkOutput("rdData", rd, D1);
        checkOutput("rdErr", er, 0);
        checkOutput("rdNoWrite", aw, 0);
        checkOutput("rdCeCnt", edc_ce_cnt, 0);
        checkOutput("rdUeCnt", edc_ue_cnt, 0);

        // Single-bit error in lane 2 bit 17
        w0 = memWrites;
        flipMask = '0; flipMask[95] = 1'b1;
        applyStimulus(1'b0, 32'h50, 16'hFFFF, '0, 1'b0, rd, er, lat, aw);
        checkOutput("ceData", rd, D1);
        checkOutput("ceErr", er, 0);
        checkOutput("ceCnt", edc_ce_cnt, 1);
        checkOutput("ceErrAdr", edc_err_adr, 5);
        checkOutput("ceWriteback", aw, EXP_WB);
        checkOutput("ceWriteCount", memWrites - w0, EXP_WB);

        // Double error in lane 0, then partial write over it
        flipMask = '0; flipMask[0] = 1'b1; flipMask[1] = 1'b1;
        applyStimulus(1'b0, 32'h50, 16'hFFFF, '0, 1'b0, rd, er, lat, aw);
        checkOutput("ueErr", er, 1);
        checkOutput("ueRawData", rd, 128'h0123456789ABCDEF_0123456789ABCDEC);
        checkOutput("ueCnt", edc_ue_cnt, 1);
        checkOutput("ueCeCnt", edc_ce_cnt, 1);
        w0 = memWrites;
        applyStimulus(1'b1, 32'h50, 16'h000F, AAAA, 1'b0, rd, er, lat, aw);
        checkOutput("uePwLat", lat, 3);
        checkOutput("uePwErr", er, 1);
        checkOutput("uePwAckWrite", aw, 0);
        checkOutput("uePwWriteCount", memWrites - w0, 0);
        checkOutput("uePwMem", {mem[5][148:117], mem[5][109:78], mem[5][70:39], mem[5][31:0]}, D1);
        checkOutput("uePwUeCnt", edc_ue_cnt, 2);
        flipMask = '0;

        // Partial write merge over word 3
        applyStimulus(1'b1, 32'h30, 16'hFFFF, ONES1, 1'b0, rd, er, lat, aw);
        w0 = memWrites;
        applyStimulus(1'b1, 32'h30, 16'h000F, AAAA, 1'b0, rd, er, lat, aw);
        checkOutput("pwLat", lat, 3);
        checkOutput("pwErr", er, 0);
        checkOutput("pwAckWrite", aw, 1);
        checkOutput("pwWriteCount", memWrites - w0, 1);
        checkOutput("pwMem", {mem[3][148:117], mem[3][109:78], mem[3][70:39], mem[3][31:0]},
                    128'h11111111_11111111_11111111_AAAAAAAA);
        for (int l = 0; l < 4; l++) checkOutput("pwClean", laneClean(mem[3][39*l +: 39]), 1);

        // Hand-encoded check bits: data 1 -> 0x43, data 0x80000000 -> 0x26
        applyStimulus(1'b1, 32'h70, 16'hFFFF, 128'h0_0_80000000_00000001, 1'b0, rd, er, lat, aw);
        checkOutput("encLane0", mem[7][38:0], {7'h43, 32'h00000001});
        checkOutput("encLane1", mem[7][77:39], {7'h26, 32'h80000000});
        checkOutput("encLane23", mem[7][155:78], 0);

        // Zero-filled word reads clean
        applyStimulus(1'b0, 32'h90, 16'h0000, '0, 1'b0, rd, er, lat, aw);
        checkOutput("zeroData", rd, 0);
        checkOutput("zeroErr", er, 0);
        checkOutput("zeroCeCnt", edc_ce_cnt, 1);

        // Drive ce_cnt up to saturation with single-bit errors at varied positions
        for (int i = 0; i < 14; i++) begin
            flipMask = '0;
            flipMask[(i * 11) % 39 + 39 * (i % 4)] = 1'b1;
            applyStimulus(1'b0, 32'h50, 16'hFFFF, '0, 1'b0, rd, er, lat, aw);
            checkOutput("satData", rd, D1);
        end
        checkOutput("satReach", edc_ce_cnt, 15);
        flipMask = '0; flipMask[77] = 1'b1;
        applyStimulus(1'b0, 32'h50, 16'hFFFF, '0, 1'b0, rd, er, lat, aw);
        checkOutput("satHold", edc_ce_cnt, 15);
        checkOutput("satC6Data", rd, D1);

        // Clear coincident with a CE access in FIN
        applyStimulus(1'b0, 32'h50, 16'hFFFF, '0, 1'b1, rd, er, lat, aw);
        checkOutput("clrCeCnt", edc_ce_cnt, 0);
        checkOutput("clrUeCnt", edc_ue_cnt, 0);
        checkOutput("clrErrAdr", edc_err_adr, 0);
        flipMask = '0; flipMask[140] = 1'b1;
        applyStimulus(1'b0, 32'h30, 16'hFFFF, '0, 1'b0, rd, er, lat, aw);
        checkOutput("postClrData", rd, 128'h11111111_11111111_11111111_AAAAAAAA);
        checkOutput("postClrCeCnt", edc_ce_cnt, 1);
        checkOutput("postClrErrAdr", edc_err_adr, 3);
        flipMask = '0;

        // stb with cyc low is not an access
        sawAck = 1'b0; sawReq = 1'b0;
        edc_wb_cyc = 1'b0; edc_wb_stb = 1'b1; edc_wb_we = 1'b1; edc_wb_sel = 16'hFFFF;
        repeat (4) begin
            @(posedge edc_clk);
            #1;
            sawAck = sawAck | edc_wb_ack;
            sawReq = sawReq | mem_req;
        end
        edc_wb_stb = 1'b0;
        checkOutput("cycLowAck", sawAck, 0);
        checkOutput("cycLowReq", sawReq, 0);

        // Reset during CHK of a partial write abandons the RMW
        w0 = memWrites;
        edc_wb_we = 1'b1; edc_wb_adr = 32'h30; edc_wb_sel = 16'h000F; edc_wb_dat_w = AAAA;
        edc_wb_cyc = 1'b1; edc_wb_stb = 1'b1;
        @(posedge edc_clk);
        #1;
        edc_wb_cyc = 1'b0; edc_wb_stb = 1'b0;
        @(posedge edc_clk);
        #1;
        edc_rst_n = 1'b0;
        @(posedge edc_clk);
        #1;
        checkOutput("midRstAck", edc_wb_ack, 0);
        checkOutput("midRstMemReq", mem_req, 0);
        checkOutput("midRstCeCnt", edc_ce_cnt, 0);
        checkOutput("midRstErrAdr", edc_err_adr, 0);
        sawAck = 1'b0;
        repeat (2) begin
            @(posedge edc_clk);
            #1;
            sawAck = sawAck | edc_wb_ack;
        end
        checkOutput("midRstNoAck", sawAck, 0);
        checkOutput("midRstNoWrite", memWrites - w0, 0);
        edc_rst_n = 1'b1;
        @(posedge edc_clk);
        #1;
        applyStimulus(1'b1, 32'h20, 16'hFFFF, D1, 1'b0, rd, er, lat, aw);
        checkOutput("postRstWrLat", lat, 1);
        applyStimulus(1'b0, 32'h20, 16'hFFFF, '0, 1'b0, rd, er, lat, aw);
        checkOutput("postRstRdLat", lat, 3);
        checkOutput("postRstRdData", rd, D1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
